qoi_decoder: RTL and testbench

//   Streaming QOI chunk decoder; the inverse of the team's QOI encoder.

---
 rtl/qoi_dec_if.sv | 25 ++
 rtl/qoi_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_qoi_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_dec_if.sv
// Stream interface for the QOI chunk decoder: a chunk byte stream in and an
// RGBA pixel stream out, each with a valid/ready handshake, plus the sticky
// protocol error flag. The decoder connects through the slave modport.
interface qoi_dec_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, r, g, b, a, out_valid, err
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, r, g, b, a, out_valid, err
  );
endinterface

// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder. Takes the chunk byte stream (header stripped)
// and emits one RGBA pixel per output beat, expanding runs and tracking the
// previous pixel and the 64-entry colour index.
// The output register doubles as the "previous pixel" of the QOI algorithm.
// Optional feature macro: QOI_DEC_RGBA_EN (decode 0xFF as an RGBA chunk;
// when undefined, 0xFF is dropped and raises the sticky err flag).
module qoi_decoder #(
  parameter bit         CLEAR_INDEX = 1'b1,
  parameter logic [7:0] ALPHA_INIT  = 8'hFF
) (
  input logic      clk,
  input logic      rst,
  qoi_dec_if.slave bus
);

  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_OP = 2'd1, S_ARG = 2'd2, S_RUN = 2'd3} state_e;
  typedef enum logic [1:0] {K_RGB = 2'd0, K_RGBA = 2'd1, K_LUMA = 2'd2} kind_e;

`ifdef QOI_DEC_RGBA_EN
  localparam int BUF_W = 24;
`else
  localparam int BUF_W = 16;
`endif

  // Colour index position of a pixel {r,g,b,a}: (r*3+g*5+b*7+a*11) mod 64.
  function automatic logic [5:0] qoi_hash(input logic [31:0] px);
    qoi_hash = px[29:24] * 6'd3 + px[21:16] * 6'd5 + px[13:8] * 6'd7 + px[5:0] * 6'd11;
  endfunction

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [5:0]         clr_q, clr_d;
  logic [2:0]         arg_q, arg_d;
  logic [5:0]         run_q, run_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [31:0]        pix_q, pix_d;
  logic               out_valid_q, out_valid_d;
`ifndef QOI_DEC_RGBA_EN
  logic               err_q, err_d;
`endif

  logic [31:0] index_q [64];

  logic        slot_free_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        load_s;
  logic [31:0] new_pix_s;
  logic [7:0]  dg_s;
  logic        idx_we_s;
  logic [5:0]  idx_waddr_s;
  logic [31:0] idx_wdata_s;

  // Next-state, chunk decode, pixel load and index write selection.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    clr_d       = clr_q;
    arg_d       = arg_q;
    run_d       = run_q;
    buf_d       = buf_q;
    pix_d       = pix_q;
    out_valid_d = out_valid_q;
`ifndef QOI_DEC_RGBA_EN
    err_d       = err_q;
`endif
    load_s      = 1'b0;
    new_pix_s   = pix_q;
    dg_s        = 8'd0;
    idx_we_s    = 1'b0;
    idx_waddr_s = clr_q;
    idx_wdata_s = 32'd0;

    slot_free_s = !out_valid_q || bus.out_ready;
    in_ready_s  = slot_free_s && ((state_q == S_OP) || (state_q == S_ARG));
    accept_s    = in_ready_s && bus.in_valid;

    case (state_q)
      S_CLEAR: begin
        idx_we_s = 1'b1;
        clr_d    = clr_q + 6'd1;
        if (clr_q == 6'd63) state_d = S_OP;
        else                state_d = S_CLEAR;
      end
      S_OP: begin
        if (accept_s) begin
          buf_d = {buf_q[BUF_W-9:0], bus.in_data};
          if (bus.in_data == 8'hFE) begin
            kind_d  = K_RGB;
            arg_d   = 3'd3;
            state_d = S_ARG;
          end else if (bus.in_data == 8'hFF) begin
`ifdef QOI_DEC_RGBA_EN
            kind_d  = K_RGBA;
            arg_d   = 3'd4;
            state_d = S_ARG;
`else
            err_d   = 1'b1;
`endif
          end else begin
            case (bus.in_data[7:6])
              2'b00: begin
                load_s    = 1'b1;
                new_pix_s = index_q[bus.in_data[5:0]];
              end
              2'b01: begin
                load_s    = 1'b1;
                new_pix_s = {pix_q[31:24] + {6'd0, bus.in_data[5:4]} - 8'd2,
                             pix_q[23:16] + {6'd0, bus.in_data[3:2]} - 8'd2,
                             pix_q[15:8]  + {6'd0, bus.in_data[1:0]} - 8'd2,
                             pix_q[7:0]};
              end
              2'b10: begin
                kind_d  = K_LUMA;
                arg_d   = 3'd1;
                state_d = S_ARG;
              end
              default: begin
                // First run pixel leaves with the opcode; the rest come from S_RUN.
                load_s    = 1'b1;
                new_pix_s = pix_q;
                run_d     = bus.in_data[5:0];
                if (bus.in_data[5:0] != 6'd0) state_d = S_RUN;
                else                          state_d = S_OP;
              end
            endcase
          end
        end else begin
          state_d = S_OP;
        end
      end
      S_ARG: begin
        if (accept_s) begin
          buf_d = {buf_q[BUF_W-9:0], bus.in_data};
          arg_d = arg_q - 3'd1;
          if (arg_q == 3'd1) begin
            load_s  = 1'b1;
            state_d = S_OP;
            case (kind_q)
              K_LUMA: begin
                dg_s      = {2'b00, buf_q[5:0]} - 8'd32;
                new_pix_s = {pix_q[31:24] + dg_s + {4'd0, bus.in_data[7:4]} - 8'd8,
                             pix_q[23:16] + dg_s,
                             pix_q[15:8]  + dg_s + {4'd0, bus.in_data[3:0]} - 8'd8,
                             pix_q[7:0]};
              end
`ifdef QOI_DEC_RGBA_EN
              K_RGBA:  new_pix_s = {buf_q[23:0], bus.in_data};
`endif
              default: new_pix_s = {buf_q[15:0], bus.in_data, pix_q[7:0]};
            endcase
          end else begin
            state_d = S_ARG;
          end
        end else begin
          state_d = S_ARG;
        end
      end
      S_RUN: begin
        if (slot_free_s) begin
          load_s    = 1'b1;
          new_pix_s = pix_q;
          run_d     = run_q - 6'd1;
          if (run_q == 6'd1) state_d = S_OP;
          else               state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_OP;
    endcase

    if (load_s) begin
      pix_d       = new_pix_s;
      out_valid_d = 1'b1;
      idx_we_s    = 1'b1;
      idx_waddr_s = qoi_hash(new_pix_s);
      idx_wdata_s = new_pix_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CLEAR_INDEX ? S_CLEAR : S_OP;
      kind_q      <= K_RGB;
      clr_q       <= 6'd0;
      arg_q       <= 3'd0;
      run_q       <= 6'd0;
      buf_q       <= '0;
      pix_q       <= {24'd0, ALPHA_INIT};
      out_valid_q <= 1'b0;
`ifndef QOI_DEC_RGBA_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      clr_q       <= clr_d;
      arg_q       <= arg_d;
      run_q       <= run_d;
      buf_q       <= buf_d;
      pix_q       <= pix_d;
      out_valid_q <= out_valid_d;
`ifndef QOI_DEC_RGBA_EN
      err_q       <= err_d;
`endif
    end
  end

  // Colour index storage: clear sweep or emitted-pixel write, never during reset.
  always_ff @(posedge clk) begin
    if (rst && idx_we_s) begin
      index_q[idx_waddr_s] <= idx_wdata_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.r         = pix_q[31:24];
  assign bus.g         = pix_q[23:16];
  assign bus.b         = pix_q[15:8];
  assign bus.a         = pix_q[7:0];
`ifdef QOI_DEC_RGBA_EN
  assign bus.err       = 1'b0;
`else
  assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_qoi_decoder.sv
// Self-checking bench for qoi_decoder: a chunk-level QOI model predicts the
// pixel stream into a queue that a per-cycle monitor compares against the DUT,
// plus literal expectations taken from worked examples.
module tb_qoi_decoder;
  logic clk;
  logic rst;
  qoi_dec_if bus ();

  qoi_decoder #(.CLEAR_INDEX(1'b1), .ALPHA_INIT(8'hFF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int mon_pops = 0;

  logic [31:0] exp_q [$];
  logic [31:0] m_prev;
  logic [31:0] m_index [64];
  logic [7:0]  m_pend [$];
  logic        m_err;

  logic [31:0] dut_pix;
  assign dut_pix = {bus.r, bus.g, bus.b, bus.a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [5:0] m_hash(input logic [31:0] p);
    int s;
    s = int'(p[31:24]) * 3 + int'(p[23:16]) * 5 + int'(p[15:8]) * 7 + int'(p[7:0]) * 11;
    return 6'(s % 64);
  endfunction

  function automatic logic [7:0] addw(input logic [7:0] x, input int d);
    int t;
    t = int'(x) + d;
    return t[7:0];
  endfunction

  task automatic model_reset();
    m_prev = 32'h000000FF;
    for (int i = 0; i < 64; i++) m_index[i] = 32'd0;
    m_pend.delete();
    m_err = 1'b0;
  endtask

  task automatic model_emit(input logic [31:0] p);
    exp_q.push_back(p);
    m_prev = p;
    m_index[m_hash(p)] = p;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] op;
    logic [7:0] a1;
    int dg;
    m_pend.push_back(b);
    op = m_pend[0];
    if (op == 8'hFE) begin
      if (m_pend.size() == 4) begin
        model_emit({m_pend[1], m_pend[2], m_pend[3], m_prev[7:0]});
        m_pend.delete();
      end
    end else if (op == 8'hFF) begin
`ifdef QOI_DEC_RGBA_EN
      if (m_pend.size() == 5) begin
        model_emit({m_pend[1], m_pend[2], m_pend[3], m_pend[4]});
        m_pend.delete();
      end
`else
      m_err = 1'b1;
      m_pend.delete();
`endif
    end else if (op[7:6] == 2'b00) begin
      model_emit(m_index[op[5:0]]);
      m_pend.delete();
    end else if (op[7:6] == 2'b01) begin
      model_emit({addw(m_prev[31:24], int'(op[5:4]) - 2), addw(m_prev[23:16], int'(op[3:2]) - 2),
                  addw(m_prev[15:8], int'(op[1:0]) - 2), m_prev[7:0]});
      m_pend.delete();
    end else if (op[7:6] == 2'b10) begin
      if (m_pend.size() == 2) begin
        a1 = m_pend[1];
        dg = int'(op[5:0]) - 32;
        model_emit({addw(m_prev[31:24], dg + int'(a1[7:4]) - 8), addw(m_prev[23:16], dg),
                    addw(m_prev[15:8], dg + int'(a1[3:0]) - 8), m_prev[7:0]});
        m_pend.delete();
      end
    end else begin
      for (int i = 0; i <= int'(op[5:0]); i++) model_emit(m_prev);
      m_pend.delete();
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic        stall_tb;
  logic [31:0] last_pix_tb;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      stall_tb = 1'b0;
    end else begin
      if (stall_tb) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", dut_pix, last_pix_tb);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", dut_pix, 32'hXXXXXXXX);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", dut_pix, e);
          mon_pops++;
        end
      end
      chk("err", {31'd0, bus.err}, {31'd0, m_err});
      stall_tb    = bus.out_valid && !bus.out_ready;
      last_pix_tb = dut_pix;
    end
  end

  // ---------------- drivers ----------------
  task automatic put_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n >= 300) begin
        chk("accept_timeout", 32'(n), 32'd0);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    model_byte(b);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Reset, check reset values, count clear cycles with b0 presented, accept b0.
  task automatic do_reset(input logic [7:0] b0);
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    model_reset();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_pixel", dut_pix, 32'h000000FF);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
    end
    chk("clear_cycles", 32'(n), 32'd64);
    @(posedge clk);
    #1;
    model_byte(b0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;
    model_reset();

    // 1: reset release with a byte waiting, then RGB chunk
    do_reset(8'hFE);
    put_byte(8'h10);
    put_byte(8'h20);
    put_byte(8'h30);
    chk("rgb_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rgb_pixel", dut_pix, 32'h102030FF);

    // 2: DIFF and LUMA
    put_byte(8'h7B);
    chk("diff_pixel", dut_pix, 32'h112031FF);
    put_byte(8'hA5);
    put_byte(8'h97);
    chk("luma_pixel", dut_pix, 32'h172535FF);

    // 3: INDEX hit on (10,20,30,FF)
    put_byte(8'h15);
    chk("index_pixel", dut_pix, 32'h102030FF);
    drain();

    // 4a: short run, in_ready low while running
    p0 = mon_pops;
    put_byte(8'hC2);
    @(negedge clk);
    chk("run_in_ready0", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("run_in_ready1", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("run_exit_ready", {31'd0, bus.in_ready}, 32'd1);
    drain();
    chk("run3_count", 32'(mon_pops - p0), 32'd3);

    // 4b: run with two stalled cycles
    p0 = mon_pops;
    put_byte(8'hC2);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("run_stall_pixel", dut_pix, 32'h102030FF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    chk("run_stall_count", 32'(mon_pops - p0), 32'd3);

    // 4c: maximum run
    p0 = mon_pops;
    put_byte(8'hFD);
    drain();
    chk("run62_count", 32'(mon_pops - p0), 32'd62);

    // 5: backpressure blocks input
    p0 = mon_pops;
    bus.out_ready = 1'b0;
    put_byte(8'h55);
    chk("bp_pixel", dut_pix, 32'h0F1F2FFF);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    put_byte(8'h7F);
    chk("bp_resume_pixel", dut_pix, 32'h102030FF);
    drain();
    chk("bp_count", 32'(mon_pops - p0), 32'd2);

    // 6a: reset mid-RGB, then DIFF wraps from (0,0,0,FF)
    put_byte(8'hFE);
    put_byte(8'h10);
    do_reset(8'h40);
    chk("wrap_pixel", dut_pix, 32'hFEFEFEFF);
    drain();

    // 6b: reset mid-run, then INDEX 0 of the cleared table
    put_byte(8'hFD);
    repeat (5) @(posedge clk);
    #1;
    do_reset(8'h00);
    chk("index0_pixel", dut_pix, 32'h00000000);
    drain();

    // 6c: 0xFF chunk
    p0 = mon_pops;
    put_byte(8'hFF);
`ifdef QOI_DEC_RGBA_EN
    put_byte(8'h01);
    put_byte(8'h02);
    put_byte(8'h03);
    put_byte(8'h04);
    chk("rgba_pixel", dut_pix, 32'h01020304);
    drain();
    chk("rgba_count", 32'(mon_pops - p0), 32'd1);
    chk("rgba_err", {31'd0, bus.err}, 32'd0);
`else
    chk("ff_err", {31'd0, bus.err}, 32'd1);
    chk("ff_no_pixel", {31'd0, bus.out_valid}, 32'd0);
    put_byte(8'h01);
    put_byte(8'h02);
    put_byte(8'h03);
    put_byte(8'h04);
    chk("ff_index_pixel", dut_pix, 32'h00000000);
    drain();
    chk("ff_count", 32'(mon_pops - p0), 32'd4);
    chk("ff_err_sticky", {31'd0, bus.err}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
